cordic_freq_discr: RTL and testbench

//  Downstream stage of cordic_atan_iq. Consumes the per-sample angle and the unscaled radius.
//  - Removes the CORDIC gain from the radius to give amplitude.
//  - Forms the wrapped phase difference between consecutive samples (instantaneous frequency).
//  - Averages and decimates that difference by 2**LOG2_DEC.
//  - Gates both paths with an amplitude squelch.

---
 rtl/cordic_freq_discr_pkg.sv | 22 ++
 rtl/cordic_freq_discr_gain_comp.sv | 38 +++
 rtl/cordic_freq_discr.sv | 129 ++++++++++++
 tb/tb_cordic_freq_discr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_freq_discr_pkg.sv
// Shared constants and types for the CORDIC frequency discriminator.
package cordic_freq_discr_pkg;

    // CORDIC gain correction factor K = 0.607253 in Q16
    localparam int unsigned K_Q16 = 39797;

    typedef logic signed [31:0] phase_t;
    typedef logic [31:0]        mag_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    // (radius * K_Q16 + 0.5 LSB) >> 16, kept to 32 bits
    function automatic mag_t remove_gain(input mag_t radius);
        logic [48:0] prod;
        prod = 49'(radius) * 49'(K_Q16) + 49'(32768);
        return mag_t'(prod >> 16);
    endfunction

endpackage

// File: rtl/cordic_freq_discr_gain_comp.sv
// Registered CORDIC gain removal; carries valid and angle alongside amp_r.
module cordic_gain_comp
    import cordic_freq_discr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] angle_i,
    input  logic [31:0] radius_i,
    output logic        valid_o,
    output logic [31:0] angle_o,
    output logic [31:0] amp_o
);

    logic   valid_q;
    phase_t angle_q;
    mag_t   amp_q;

    // Stage 1: capture angle and gain-corrected radius on each accepted sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            angle_q <= '0;
            amp_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                angle_q <= angle_i;
                amp_q   <= remove_gain(radius_i);
            end
        end
    end

    assign valid_o = valid_q;
    assign angle_o = angle_q;
    assign amp_o   = amp_q;

endmodule

// File: rtl/cordic_freq_discr.sv
// Frequency discriminator: wrapped phase difference, averaged and decimated,
// gated by an amplitude squelch.
module cordic_freq_discr
    import cordic_freq_discr_pkg::*;
#(
    parameter int unsigned LOG2_DEC  = 2,
    parameter logic [31:0] SQ_THRESH = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] angle,
    input  logic [31:0] coe_radius,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic [31:0] amp,
    output logic        amp_valid,
    output logic        squelch
);

    localparam int unsigned ACC_W = 32 + LOG2_DEC;
    localparam int unsigned CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DEC) - 1);

    logic   s1_valid;
    phase_t s1_angle;
    mag_t   s1_amp;

    cordic_gain_comp u_gain (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (in_valid),
        .angle_i  (angle),
        .radius_i (coe_radius),
        .valid_o  (s1_valid),
        .angle_o  (s1_angle),
        .amp_o    (s1_amp)
    );

    state_e                   state_q, state_d;
    phase_t                   prev_q, prev_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    phase_t                   freq_q, freq_d;
    logic                     fv_q, fv_d;
    mag_t                     amp_q, amp_d;
    logic                     av_q, av_d;
    logic                     sq_q, sq_d;

    phase_t                   diff;
    logic signed [ACC_W-1:0]  sum;

    // Wrapped step: 32-bit modular subtraction read as signed handles the +/-180 deg seam
    assign diff = s1_angle - prev_q;
    assign sum  = acc_q + ACC_W'(diff);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRIME;
            prev_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            fv_q    <= 1'b0;
            amp_q   <= '0;
            av_q    <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            fv_q    <= fv_d;
            amp_q   <= amp_d;
            av_q    <= av_d;
            sq_q    <= sq_d;
        end
    end

    // Stage 2: squelch gate, FSM and accumulate/decimate
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        fv_d    = 1'b0;
        amp_d   = amp_q;
        av_d    = 1'b0;
        sq_d    = sq_q;
        if (s1_valid) begin
            amp_d = s1_amp;
            av_d  = 1'b1;
            if (s1_amp < SQ_THRESH) begin
                sq_d    = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = PRIME;
            end else begin
                sq_d   = 1'b0;
                prev_d = s1_angle;
                case (state_q)
                    PRIME: state_d = RUN;
                    RUN: begin
                        if (cnt_q == CNT_LAST) begin
                            freq_d = phase_t'(sum >>> LOG2_DEC);
                            fv_d   = 1'b1;
                            acc_d  = '0;
                            cnt_d  = '0;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_d = PRIME;
                endcase
            end
        end
    end

    assign freq       = freq_q;
    assign freq_valid = fv_q;
    assign amp        = amp_q;
    assign amp_valid  = av_q;
    assign squelch    = sq_q;

endmodule

// File: tb/tb_cordic_freq_discr.sv
// Randomized and directed bench for cordic_freq_discr with a sample-level reference model.
module tb_cordic_freq_discr;

    localparam int unsigned L   = 2;
    localparam logic [31:0] TH  = 32'd1024;
    localparam logic [31:0] BIG = 32'h40000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] angle = '0;
    logic [31:0] coe_radius = '0;
    logic [31:0] freq, amp;
    logic        freq_valid, amp_valid, squelch;

    cordic_freq_discr #(.LOG2_DEC(L), .SQ_THRESH(TH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .angle      (angle),
        .coe_radius (coe_radius),
        .freq       (freq),
        .freq_valid (freq_valid),
        .amp        (amp),
        .amp_valid  (amp_valid),
        .squelch    (squelch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vectors = 0;
    int errs = 0;
    int fv_count = 0;

    // Expected events keyed by the checker cycle on which they must appear
    logic [31:0] exp_freq[int];
    logic [31:0] exp_amp[int];
    logic        exp_sq[int];
    logic [31:0] h_freq = '0;
    logic [31:0] h_amp = '0;
    logic        h_sq = 1'b0;

    // Reference model state: primed flag, previous angle, diffs of current group
    bit          primed = 1'b0;
    logic [31:0] prev = '0;
    int          diffs[$];

    function automatic logic [31:0] amp_of(input logic [31:0] r);
        logic [63:0] p;
        p = 64'(r) * 64'd39797 + 64'd32768;
        return p[47:16];
    endfunction

    task automatic model_sample(input logic [31:0] a, input logic [31:0] r);
        logic [31:0] am;
        longint      s;
        int          k;
        k  = cyc + 2;
        am = amp_of(r);
        exp_amp[k] = am;
        if (am < TH) begin
            exp_sq[k] = 1'b1;
            diffs.delete();
            primed = 1'b0;
        end else begin
            exp_sq[k] = 1'b0;
            if (primed) begin
                diffs.push_back(int'(a - prev));
                if (diffs.size() == (1 << L)) begin
                    s = 0;
                    foreach (diffs[i]) s += longint'(diffs[i]);
                    s = s >>> L;
                    exp_freq[k] = s[31:0];
                    diffs.delete();
                end
            end
            prev   = a;
            primed = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_freq.delete();
        exp_amp.delete();
        exp_sq.delete();
        h_freq = '0;
        h_amp  = '0;
        h_sq   = 1'b0;
        diffs.delete();
        primed = 1'b0;
        prev   = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, #1 after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_freq.exists(cyc)) h_freq = exp_freq[cyc];
            if (exp_amp.exists(cyc)) begin
                h_amp = exp_amp[cyc];
                h_sq  = exp_sq[cyc];
            end
            chk("freq_valid", {31'b0, freq_valid}, {31'b0, exp_freq.exists(cyc) != 0});
            chk("amp_valid",  {31'b0, amp_valid},  {31'b0, exp_amp.exists(cyc) != 0});
            chk("freq",    freq, h_freq);
            chk("amp",     amp,  h_amp);
            chk("squelch", {31'b0, squelch}, {31'b0, h_sq});
            if (freq_valid) fv_count++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] r);
        @(negedge clk);
        in_valid   = 1'b1;
        angle      = a;
        coe_radius = r;
        model_sample(a, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid   = 1'b0;
            angle      = $urandom;
            coe_radius = $urandom;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        fv_count = 0;
    endtask

    initial begin
        logic [31:0] a, step, r;
        model_reset();
        idle(2);
        chk("reset_freq", freq, 32'h0);
        chk("reset_amp",  amp,  32'h0);
        chk("reset_flags", {29'b0, freq_valid, amp_valid, squelch}, 32'h0);
        do_reset();

        // Linear ramp: one freq per four steps after priming
        for (int n = 0; n <= 8; n++) send(32'(n) * 32'h01000000, BIG);
        idle(3);
        chk("ramp_freq",   freq, 32'h01000000);
        chk("ramp_pulses", 32'(fv_count), 32'd2);
        chk("gain_amp",    amp,  32'h26DD4000);

        // Crossing +180 deg
        do_reset();
        a = 32'h7F000000;
        for (int n = 0; n < 9; n++) begin
            send(a, BIG);
            a = a + 32'h02000000;
        end
        idle(3);
        chk("wrap_freq", freq, 32'h02000000);

        // Reverse rotation through zero
        do_reset();
        a = 32'h0;
        for (int n = 0; n < 9; n++) begin
            send(a, BIG);
            a = a - 32'h00100000;
        end
        idle(3);
        chk("rev_freq", freq, 32'hFFF00000);

        // Squelch mid-group, then five fresh samples
        do_reset();
        for (int n = 0; n < 3; n++) send(32'(n) * 32'h01000000, BIG);
        send(32'h03000000, 32'd1000);
        idle(2);
        chk("sq_on",  {31'b0, squelch}, 32'h1);
        chk("sq_amp", amp, 32'd607);
        for (int n = 0; n < 5; n++) send(32'h10000000 + 32'(n) * 32'h01000000, BIG);
        idle(3);
        chk("sq_off",    {31'b0, squelch}, 32'h0);
        chk("sq_pulses", 32'(fv_count), 32'd1);

        // Gappy input and reset after two samples
        do_reset();
        send(32'h0, BIG);
        idle(1);
        send(32'h00100000, BIG);
        do_reset();
        for (int n = 0; n < 5; n++) begin
            send(32'(n) * 32'h00200000, BIG);
            idle(1);
        end
        idle(3);
        chk("gap_freq",   freq, 32'h00200000);
        chk("gap_pulses", 32'(fv_count), 32'd1);

        // Randomized traffic
        do_reset();
        a    = $urandom;
        step = $urandom_range(0, 32'h08000000) - 32'h04000000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                if ($urandom_range(0, 9) == 0) step = $urandom;
                if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 2000);
                else r = $urandom;
                a = a + step + ($urandom_range(0, 255) - 128);
                send(a, r);
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
